// File: rtl/clk_meas.sv
`default_nettype none
// ============================================================================
// Module   : clk_meas
// Brief    : Measures period and high time of a slow asynchronous signal in
//            clk_in cycles, one result per complete period with valid strobe.
//            Optional idle timeout enabled by defining MEAS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clk_meas #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             ovf,
    output logic             timeout
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_ARM  = 2'd1;
    localparam logic [1:0]       c_ST_MEAS = 2'd2;
    localparam logic [CNT_W-1:0] c_SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_sync1;
    logic             r_s;
    logic             r_s_d;
    logic             w_rise;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_p_cnt;
    logic [CNT_W-1:0] r_h_cnt;
    logic             r_timeout;
    logic             w_to_hit;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
        end
    end

    assign w_rise = r_s & ~r_s_d;

`ifdef MEAS_TIMEOUT_EN
    localparam int                c_IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT - 1);

    logic [c_IDLE_W-1:0] r_idle;

    // Counts cycles since entering ARM or since the last rising edge.
    always_ff @(posedge clk_in) begin
        if (rst || !en || (r_state == c_ST_IDLE) || w_rise || w_to_hit) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end

    assign w_to_hit = en && (r_state != c_ST_IDLE) && !w_rise && (r_idle == c_IDLE_MAX);
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_state_next = c_ST_ARM;
                c_ST_ARM:  if (w_rise) w_state_next = c_ST_MEAS;
                c_ST_MEAS: if (w_to_hit) w_state_next = c_ST_ARM;
                default:   w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_p_cnt    <= '0;
            r_h_cnt    <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                r_p_cnt   <= '0;
                r_h_cnt   <= '0;
                ovf       <= 1'b0;
                r_timeout <= 1'b0;
            end else if (r_state != c_ST_IDLE) begin
                if (w_rise) begin
                    // A rise in MEAS closes the running period; in ARM it only opens one.
                    if (r_state == c_ST_MEAS) begin
                        if (r_p_cnt != c_SAT) begin
                            period_out <= r_p_cnt + c_ONE;
                            high_out   <= r_h_cnt;
                            valid      <= 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    r_p_cnt <= '0;
                    r_h_cnt <= c_ONE;
                end else if (w_to_hit) begin
                    r_timeout  <= 1'b1;
                    period_out <= '0;
                    high_out   <= '0;
                    r_p_cnt    <= '0;
                    r_h_cnt    <= '0;
                end else if (r_state == c_ST_MEAS) begin
                    if (r_p_cnt != c_SAT) r_p_cnt <= r_p_cnt + c_ONE;
                    if (r_s && (r_h_cnt != c_SAT)) r_h_cnt <= r_h_cnt + c_ONE;
                end
            end
        end
    end

    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clk_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_meas
// Brief    : Self-checking bench for clk_meas; two instances (CNT_W 16 and 4)
//            share one stimulus and are compared against an event-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clk_meas;

    localparam int TO = 100;
`ifdef MEAS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] p16, h16;
    logic        v16, o16, t16;
    logic [3:0]  p4, h4;
    logic        v4, o4, t4;

    always #5 clk_in = ~clk_in;

    clk_meas #(.CNT_W(16), .TIMEOUT(TO)) u_dut16 (
        .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
        .period_out(p16), .high_out(h16), .valid(v16), .ovf(o16), .timeout(t16)
    );

    clk_meas #(.CNT_W(4), .TIMEOUT(TO)) u_dut4 (
        .clk_in(clk_in), .rst(rst), .en(en), .sig_in(sig_in),
        .period_out(p4), .high_out(h4), .valid(v4), .ovf(o4), .timeout(t4)
    );

    wire [45:0] w_act = {v16, o16, t16, p16, h16, v4, o4, t4, p4, h4};

    int checks = 0;
    int passes = 0;

    // Reference model: sample history plus, per instance, the edge index of the
    // accepted period start. mode 0 = disabled, 1 = waiting for first rise, 2 = measuring.
    int n = 8;
    bit samp [0:65535];
    int wid    [2] = '{16, 4};
    int mode   [2] = '{0, 0};
    int start  [2] = '{0, 0};
    int last   [2] = '{0, 0};
    int e_per  [2] = '{0, 0};
    int e_high [2] = '{0, 0};
    bit e_val  [2] = '{0, 0};
    bit e_ovf  [2] = '{0, 0};
    bit e_to   [2] = '{0, 0};

    function automatic logic [45:0] exp_vec();
        return {e_val[0], e_ovf[0], e_to[0], 16'(e_per[0]), 16'(e_high[0]),
                e_val[1], e_ovf[1], e_to[1], 4'(e_per[1]), 4'(e_high[1])};
    endfunction

    // High cycles seen by the synchronised signal over edges [a, b).
    function automatic int ones(input int a, input int b);
        int s = 0;
        for (int k = a; k < b; k++) s += int'(samp[k-2]);
        return s;
    endfunction

    task automatic step(input bit s, input bit e, input bit r);
        bit rise;
        int len;
        @(negedge clk_in);
        sig_in = s;
        en     = e;
        rst    = r;
        @(posedge clk_in);
        n++;
        samp[n] = s;
        rise = samp[n-2] && !samp[n-3];
        if (r) begin
            samp[n]   = 1'b0;
            samp[n-1] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            e_val[i] = 1'b0;
            if (r) begin
                mode[i] = 0; e_per[i] = 0; e_high[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
            end else if (!e) begin
                mode[i] = 0; e_ovf[i] = 0; e_to[i] = 0;
            end else if (mode[i] == 0) begin
                mode[i] = 1; last[i] = n;
            end else if (rise) begin
                if (mode[i] == 2) begin
                    len = n - start[i];
                    if (len <= (1 << wid[i]) - 1) begin
                        e_per[i]  = len;
                        e_high[i] = ones(start[i], n);
                        e_val[i]  = 1'b1;
                    end else begin
                        e_ovf[i] = 1'b1;
                    end
                end
                mode[i] = 2; start[i] = n; last[i] = n;
            end else if (TO_EN && (n - last[i] >= TO)) begin
                e_to[i] = 1'b1; e_per[i] = 0; e_high[i] = 0; mode[i] = 1; last[i] = n;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, c < 3);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL reset_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
        checks++;
        if (w_act !== 46'd0) $display("FAIL reset_zero got=%h want=0", w_act);
        else passes++;
    endtask

    task automatic test_square();
        int off = $urandom_range(0, 24);
        int nv  = 0;
        for (int c = 0; c < off + 3; c++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL square_model got=%h want=%h", w_act, exp_vec());
            else passes++;
        end
        for (int c = 0; c < 8 * 25; c++) begin
            step((c % 25) < 12, 1'b1, 1'b0);
            if (v16) nv++;
            checks++;
            if (w_act !== exp_vec()) $display("FAIL square_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
        checks++;
        if (p16 !== 16'd25 || h16 !== 16'd12) $display("FAIL square_result got=%0d/%0d want=25/12", p16, h16);
        else passes++;
        checks++;
        if (nv !== 7) $display("FAIL square_valid_count got=%0d want=7", nv);
        else passes++;
    endtask

    task automatic test_duty();
        int hs [2] = '{5, 24};
        int pn, ph;
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 6 * 25; c++) begin
                step((c % 25) < hs[j], 1'b1, 1'b0);
                checks++;
                if (w_act !== exp_vec()) $display("FAIL duty_model h=%0d got=%h want=%h", hs[j], w_act, exp_vec());
                else passes++;
            end
            checks++;
            if (p16 !== 16'd25 || h16 !== 16'(hs[j])) $display("FAIL duty_result got=%0d/%0d want=25/%0d", p16, h16, hs[j]);
            else passes++;
        end
        for (int r = 0; r < 4; r++) begin
            pn = $urandom_range(3, 40);
            ph = $urandom_range(1, pn - 1);
            for (int c = 0; c < 5 * pn; c++) begin
                step((c % pn) < ph, 1'b1, 1'b0);
                checks++;
                if (w_act !== exp_vec()) $display("FAIL duty_rand_model n=%0d h=%0d got=%h want=%h", pn, ph, w_act, exp_vec());
                else passes++;
            end
            checks++;
            if (p16 !== 16'(pn) || h16 !== 16'(ph)) $display("FAIL duty_rand_result got=%0d/%0d want=%0d/%0d", p16, h16, pn, ph);
            else passes++;
        end
    endtask

    task automatic test_ovf();
        int nv4 = 0;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL ovf_model got=%h want=%h", w_act, exp_vec());
            else passes++;
        end
        for (int c = 0; c < 4 * 20; c++) begin
            step((c % 20) < 10, 1'b1, 1'b0);
            if (v4) nv4++;
            checks++;
            if (w_act !== exp_vec()) $display("FAIL ovf_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
        checks++;
        if (nv4 !== 0 || o4 !== 1'b1) $display("FAIL ovf_long got valids=%0d ovf=%0b want 0/1", nv4, o4);
        else passes++;
        for (int c = 0; c < 5 * 10; c++) begin
            step((c % 10) < 3, 1'b1, 1'b0);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL ovf_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
        checks++;
        if (p4 !== 4'd10 || h4 !== 4'd3 || o4 !== 1'b1) $display("FAIL ovf_short got=%0d/%0d ovf=%0b want=10/3 ovf=1", p4, h4, o4);
        else passes++;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (o4 !== 1'b0) $display("FAIL ovf_clear got=%0b want=0", o4);
        else passes++;
    endtask

    task automatic test_en_drop();
        bit e;
        int nv = 0;
        for (int c = 0; c < 7 * 25; c++) begin
            e = !(c >= 93 && c < 98);
            step((c % 25) < 12, e, 1'b0);
            if (v16 && c >= 98 && c < 127) nv++;
            checks++;
            if (w_act !== exp_vec()) $display("FAIL endrop_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
            if (!e) begin
                checks++;
                if (p16 !== 16'd25 || h16 !== 16'd12) $display("FAIL endrop_hold got=%0d/%0d want=25/12", p16, h16);
                else passes++;
            end
        end
        checks++;
        if (nv !== 0) $display("FAIL endrop_early_valid got=%0d want=0", nv);
        else passes++;
    endtask

    task automatic test_rst_mid();
        int nv = 0;
        for (int c = 0; c < 7 * 25; c++) begin
            step((c % 25) < 12, 1'b1, c == 93);
            if (v16 && c >= 93 && c < 127) nv++;
            checks++;
            if (w_act !== exp_vec()) $display("FAIL rstmid_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
            if (c == 93) begin
                checks++;
                if (p16 !== 16'd0 || h16 !== 16'd0) $display("FAIL rstmid_clear got=%0d/%0d want=0/0", p16, h16);
                else passes++;
            end
        end
        checks++;
        if (nv !== 0) $display("FAIL rstmid_early_valid got=%0d want=0", nv);
        else passes++;
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 2 * 25 + 150; c++) begin
            step(c < 50 && (c % 25) < 12, 1'b1, 1'b0);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL timeout_model c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
        checks++;
        if (t16 !== TO_EN || p16 !== (TO_EN ? 16'd0 : 16'd25))
            $display("FAIL timeout_flag got to=%0b per=%0d want to=%0b per=%0d", t16, p16, TO_EN, TO_EN ? 0 : 25);
        else passes++;
        for (int c = 0; c < 2 * 25; c++) begin
            step((c % 25) < 12, 1'b1, 1'b0);
            checks++;
            if (w_act !== exp_vec()) $display("FAIL timeout_resume c=%0d got=%h want=%h", c, w_act, exp_vec());
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_ovf();
        test_en_drop();
        test_rst_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
